qft3_top_pipelined: RTL and testbench

QFT3_TOP_PIPELINED -- requirements
Module: qft3_top_pipelined

---
 rtl/qft3_top_pipelined.sv | 228 ++++++++++++++++++++++
 tb/tb_qft3_top_pipelined.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/qft3_top_pipelined.sv
// rtl/qft3_top_pipelined.sv - Pipelined 3-qubit QFT on signed S4.4 complex amplitudes; QFT_SATURATE_EN clamps narrowing
// Six 3-register gate stages (H / CROT) and one registered SWAP give 19 register stages.

module qft3_narrow #(
  parameter int W = 8
) (
  input  logic signed [W+5:0] v_i,
  output logic signed [W-1:0] v_o
);
`ifdef QFT_SATURATE_EN
  localparam logic signed [W+5:0] MAXV = (W+6)'((2 ** (W - 1)) - 1);
  localparam logic signed [W+5:0] MINV = (W+6)'(-(2 ** (W - 1)));

  always_comb begin
    if (v_i > MAXV) begin
      v_o = MAXV[W-1:0];
    end else if (v_i < MINV) begin
      v_o = MINV[W-1:0];
    end else begin
      v_o = v_i[W-1:0];
    end
  end
`else
  logic unused_hi;
  assign unused_hi = ^v_i[W+5:W];
  assign v_o       = v_i[W-1:0];
`endif
endmodule

module qft3_stage #(
  parameter int W    = 8,
  parameter int KIND = 0,  // 0: H, 1: CROT(pi/2), 2: CROT(pi/4)
  parameter int TGT  = 0,
  parameter int CTL  = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic signed [W-1:0] re_i [8],
  input  logic signed [W-1:0] im_i [8],
  output logic signed [W-1:0] re_o [8],
  output logic signed [W-1:0] im_o [8]
);
  localparam int KIND_H  = 0;
  localparam int KIND_R2 = 1;
  localparam int KIND_R4 = 2;
  localparam logic signed [W+5:0] K   = (W+6)'(11);
  localparam logic signed [W+5:0] RND = (W+6)'(8);

  logic signed [W-1:0] op_re_q  [8];
  logic signed [W-1:0] op_im_q  [8];
  logic signed [W:0]   ext_re   [8];
  logic signed [W:0]   ext_im   [8];
  logic signed [W:0]   mid_re_q [8];
  logic signed [W:0]   mid_im_q [8];
  logic signed [W:0]   mid_re_d [8];
  logic signed [W:0]   mid_im_d [8];
  logic signed [W-1:0] res_re_q [8];
  logic signed [W-1:0] res_im_q [8];
  logic signed [W-1:0] res_re_d [8];
  logic signed [W-1:0] res_im_d [8];

  for (genvar j = 0; j < 8; j++) begin : g_amp
    localparam int P     = j ^ (1 << TGT);
    localparam bit LO    = ((j >> TGT) & 1) == 0;
    localparam bit SEL   = (((j >> TGT) & 1) == 1) && (((j >> CTL) & 1) == 1);
    localparam bit SCALE = (KIND == KIND_H) || ((KIND == KIND_R4) && SEL);

    logic signed [W:0]   mre_d, mim_d;
    logic signed [W+5:0] mid_re_w, mid_im_w, wide_re, wide_im;

    assign ext_re[j] = {op_re_q[j][W-1], op_re_q[j]};
    assign ext_im[j] = {op_im_q[j][W-1], op_im_q[j]};

    always_comb begin
      mre_d = ext_re[j];
      mim_d = ext_im[j];
      if (KIND == KIND_H) begin
        if (LO) begin
          mre_d = ext_re[j] + ext_re[P];
          mim_d = ext_im[j] + ext_im[P];
        end else begin
          mre_d = ext_re[P] - ext_re[j];
          mim_d = ext_im[P] - ext_im[j];
        end
      end else if (SEL) begin
        if (KIND == KIND_R2) begin
          mre_d = -ext_im[j];
          mim_d = ext_re[j];
        end else begin
          mre_d = ext_re[j] - ext_im[j];
          mim_d = ext_re[j] + ext_im[j];
        end
      end
    end

    assign mid_re_d[j] = mre_d;
    assign mid_im_d[j] = mim_d;

    // Round half up: add 8 at full product width before the arithmetic shift.
    assign mid_re_w = {{5{mid_re_q[j][W]}}, mid_re_q[j]};
    assign mid_im_w = {{5{mid_im_q[j][W]}}, mid_im_q[j]};
    assign wide_re  = SCALE ? ((mid_re_w * K + RND) >>> 4) : mid_re_w;
    assign wide_im  = SCALE ? ((mid_im_w * K + RND) >>> 4) : mid_im_w;

    qft3_narrow #(.W(W)) u_nre (.v_i(wide_re), .v_o(res_re_d[j]));
    qft3_narrow #(.W(W)) u_nim (.v_i(wide_im), .v_o(res_im_d[j]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < 8; j++) begin
        op_re_q[j]  <= '0;
        op_im_q[j]  <= '0;
        mid_re_q[j] <= '0;
        mid_im_q[j] <= '0;
        res_re_q[j] <= '0;
        res_im_q[j] <= '0;
      end
    end else begin
      for (int j = 0; j < 8; j++) begin
        op_re_q[j]  <= re_i[j];
        op_im_q[j]  <= im_i[j];
        mid_re_q[j] <= mid_re_d[j];
        mid_im_q[j] <= mid_im_d[j];
        res_re_q[j] <= res_re_d[j];
        res_im_q[j] <= res_im_d[j];
      end
    end
  end

  assign re_o = res_re_q;
  assign im_o = res_im_q;
endmodule

module qft3_top_pipelined #(
  parameter int TOTAL_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic signed [TOTAL_WIDTH-1:0] i000_r,
  input  logic signed [TOTAL_WIDTH-1:0] i000_i,
  input  logic signed [TOTAL_WIDTH-1:0] i001_r,
  input  logic signed [TOTAL_WIDTH-1:0] i001_i,
  input  logic signed [TOTAL_WIDTH-1:0] i010_r,
  input  logic signed [TOTAL_WIDTH-1:0] i010_i,
  input  logic signed [TOTAL_WIDTH-1:0] i011_r,
  input  logic signed [TOTAL_WIDTH-1:0] i011_i,
  input  logic signed [TOTAL_WIDTH-1:0] i100_r,
  input  logic signed [TOTAL_WIDTH-1:0] i100_i,
  input  logic signed [TOTAL_WIDTH-1:0] i101_r,
  input  logic signed [TOTAL_WIDTH-1:0] i101_i,
  input  logic signed [TOTAL_WIDTH-1:0] i110_r,
  input  logic signed [TOTAL_WIDTH-1:0] i110_i,
  input  logic signed [TOTAL_WIDTH-1:0] i111_r,
  input  logic signed [TOTAL_WIDTH-1:0] i111_i,
  output logic signed [TOTAL_WIDTH-1:0] f000_r,
  output logic signed [TOTAL_WIDTH-1:0] f000_i,
  output logic signed [TOTAL_WIDTH-1:0] f001_r,
  output logic signed [TOTAL_WIDTH-1:0] f001_i,
  output logic signed [TOTAL_WIDTH-1:0] f010_r,
  output logic signed [TOTAL_WIDTH-1:0] f010_i,
  output logic signed [TOTAL_WIDTH-1:0] f011_r,
  output logic signed [TOTAL_WIDTH-1:0] f011_i,
  output logic signed [TOTAL_WIDTH-1:0] f100_r,
  output logic signed [TOTAL_WIDTH-1:0] f100_i,
  output logic signed [TOTAL_WIDTH-1:0] f101_r,
  output logic signed [TOTAL_WIDTH-1:0] f101_i,
  output logic signed [TOTAL_WIDTH-1:0] f110_r,
  output logic signed [TOTAL_WIDTH-1:0] f110_i,
  output logic signed [TOTAL_WIDTH-1:0] f111_r,
  output logic signed [TOTAL_WIDTH-1:0] f111_i
);
  localparam int W = TOTAL_WIDTH;

  logic signed [W-1:0] a0_re [8], a0_im [8], a1_re [8], a1_im [8];
  logic signed [W-1:0] a2_re [8], a2_im [8], a3_re [8], a3_im [8];
  logic signed [W-1:0] a4_re [8], a4_im [8], a5_re [8], a5_im [8];
  logic signed [W-1:0] a6_re [8], a6_im [8];
  logic signed [W-1:0] swp_re_q [8], swp_im_q [8];

  assign a0_re = '{i000_r, i001_r, i010_r, i011_r, i100_r, i101_r, i110_r, i111_r};
  assign a0_im = '{i000_i, i001_i, i010_i, i011_i, i100_i, i101_i, i110_i, i111_i};

  qft3_stage #(.W(W), .KIND(0), .TGT(2), .CTL(0)) u_h_q2 (
    .clk(clk), .rst_n(rst_n), .re_i(a0_re), .im_i(a0_im), .re_o(a1_re), .im_o(a1_im));
  qft3_stage #(.W(W), .KIND(1), .TGT(2), .CTL(1)) u_r2_q1q2 (
    .clk(clk), .rst_n(rst_n), .re_i(a1_re), .im_i(a1_im), .re_o(a2_re), .im_o(a2_im));
  qft3_stage #(.W(W), .KIND(2), .TGT(2), .CTL(0)) u_r4_q0q2 (
    .clk(clk), .rst_n(rst_n), .re_i(a2_re), .im_i(a2_im), .re_o(a3_re), .im_o(a3_im));
  qft3_stage #(.W(W), .KIND(0), .TGT(1), .CTL(0)) u_h_q1 (
    .clk(clk), .rst_n(rst_n), .re_i(a3_re), .im_i(a3_im), .re_o(a4_re), .im_o(a4_im));
  qft3_stage #(.W(W), .KIND(1), .TGT(1), .CTL(0)) u_r2_q0q1 (
    .clk(clk), .rst_n(rst_n), .re_i(a4_re), .im_i(a4_im), .re_o(a5_re), .im_o(a5_im));
  qft3_stage #(.W(W), .KIND(0), .TGT(0), .CTL(0)) u_h_q0 (
    .clk(clk), .rst_n(rst_n), .re_i(a5_re), .im_i(a5_im), .re_o(a6_re), .im_o(a6_im));

  // Output register doubles as SWAP(q0,q2): index bits 0 and 2 exchange.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < 8; j++) begin
        swp_re_q[j] <= '0;
        swp_im_q[j] <= '0;
      end
    end else begin
      for (int j = 0; j < 8; j++) begin
        swp_re_q[j] <= a6_re[((j & 1) << 2) | (j & 2) | ((j >> 2) & 1)];
        swp_im_q[j] <= a6_im[((j & 1) << 2) | (j & 2) | ((j >> 2) & 1)];
      end
    end
  end

  assign f000_r = swp_re_q[0];
  assign f000_i = swp_im_q[0];
  assign f001_r = swp_re_q[1];
  assign f001_i = swp_im_q[1];
  assign f010_r = swp_re_q[2];
  assign f010_i = swp_im_q[2];
  assign f011_r = swp_re_q[3];
  assign f011_i = swp_im_q[3];
  assign f100_r = swp_re_q[4];
  assign f100_i = swp_im_q[4];
  assign f101_r = swp_re_q[5];
  assign f101_i = swp_im_q[5];
  assign f110_r = swp_re_q[6];
  assign f110_i = swp_im_q[6];
  assign f111_r = swp_re_q[7];
  assign f111_i = swp_im_q[7];
endmodule

// File: tb/tb_qft3_top_pipelined.sv
// tb/tb_qft3_top_pipelined.sv - Scoreboard bench for qft3_top_pipelined
module tb_qft3_top_pipelined;
  localparam int W   = 8;
  localparam int LAT = 19;
  localparam int HI  = (1 << (W - 1)) - 1;
  localparam int LO  = -(1 << (W - 1));

  typedef logic [15:0][W-1:0] vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic signed [W-1:0] in_r [8], in_i [8], out_r [8], out_i [8];

  int   cur_r [8], cur_i [8], mr [8], mi [8];
  int   t19_r [8] = '{5, 0, -5, 0, 5, 0, -5, 0};
  int   t19_i [8] = '{0, -5, 0, 5, 0, -5, 0, 5};
  vec_t sb [$];
  vec_t exp_v, zv;
  int   errors = 0;
  int   checks = 0;
  int   nz_cycles = 0;
  int   sat_exp;

  always #5 clk = ~clk;

  qft3_top_pipelined #(.TOTAL_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i000_r(in_r[0]), .i000_i(in_i[0]), .i001_r(in_r[1]), .i001_i(in_i[1]),
    .i010_r(in_r[2]), .i010_i(in_i[2]), .i011_r(in_r[3]), .i011_i(in_i[3]),
    .i100_r(in_r[4]), .i100_i(in_i[4]), .i101_r(in_r[5]), .i101_i(in_i[5]),
    .i110_r(in_r[6]), .i110_i(in_i[6]), .i111_r(in_r[7]), .i111_i(in_i[7]),
    .f000_r(out_r[0]), .f000_i(out_i[0]), .f001_r(out_r[1]), .f001_i(out_i[1]),
    .f010_r(out_r[2]), .f010_i(out_i[2]), .f011_r(out_r[3]), .f011_i(out_i[3]),
    .f100_r(out_r[4]), .f100_i(out_i[4]), .f101_r(out_r[5]), .f101_i(out_i[5]),
    .f110_r(out_r[6]), .f110_i(out_i[6]), .f111_r(out_r[7]), .f111_i(out_i[7])
  );

  function automatic int nrw(input int v);
`ifdef QFT_SATURATE_EN
    return (v > HI) ? HI : ((v < LO) ? LO : v);
`else
    int t;
    t = v & ((1 << W) - 1);
    return (t > HI) ? t - (1 << W) : t;
`endif
  endfunction

  function automatic int scl(input int v);
    return nrw((v * 11 + 8) >>> 4);
  endfunction

  task automatic g_h(input int t);
    int m, ar, ai, br, bi;
    m = 1 << t;
    for (int j = 0; j < 8; j++) begin
      if ((j & m) == 0) begin
        ar = mr[j]; ai = mi[j]; br = mr[j | m]; bi = mi[j | m];
        mr[j] = scl(ar + br); mi[j] = scl(ai + bi);
        mr[j | m] = scl(ar - br); mi[j | m] = scl(ai - bi);
      end
    end
  endtask

  task automatic g_rot(input int c, input int t, input bit eighth);
    int r, i;
    for (int j = 0; j < 8; j++) begin
      if (((j >> c) & 1) == 1 && ((j >> t) & 1) == 1) begin
        r = mr[j]; i = mi[j];
        if (eighth) begin
          mr[j] = scl(r - i); mi[j] = scl(r + i);
        end else begin
          mr[j] = nrw(-i); mi[j] = nrw(r);
        end
      end
    end
  endtask

  task automatic g_swap02();
    int tr [8], ti [8];
    for (int j = 0; j < 8; j++) begin tr[j] = mr[j]; ti[j] = mi[j]; end
    for (int j = 0; j < 8; j++) begin
      mr[j] = tr[(j & 1) * 4 + (j & 2) + j / 4];
      mi[j] = ti[(j & 1) * 4 + (j & 2) + j / 4];
    end
  endtask

  task automatic model(output vec_t v);
    for (int j = 0; j < 8; j++) begin mr[j] = cur_r[j]; mi[j] = cur_i[j]; end
    g_h(2); g_rot(1, 2, 1'b0); g_rot(0, 2, 1'b1);
    g_h(1); g_rot(0, 1, 1'b0);
    g_h(0); g_swap02();
    for (int j = 0; j < 8; j++) begin v[j] = W'(mr[j]); v[j + 8] = W'(mi[j]); end
  endtask

  task automatic cmp_vec(input string tag, input vec_t e);
    for (int j = 0; j < 8; j++) begin
      checks++;
      assert (out_r[j] === e[j]) else begin
        errors++;
        $error("FAIL %s re[%0d] obs=%0d exp=%0d", tag, j, out_r[j], $signed(e[j]));
      end
      checks++;
      assert (out_i[j] === e[j + 8]) else begin
        errors++;
        $error("FAIL %s im[%0d] obs=%0d exp=%0d", tag, j, out_i[j], $signed(e[j + 8]));
      end
    end
  endtask

  task automatic near(input string tag, input int j, input int er, input int ei);
    int o_r, o_i;
    o_r = int'(out_r[j]);
    o_i = int'(out_i[j]);
    checks++;
    assert (o_r >= er - 1 && o_r <= er + 1) else begin
      errors++;
      $error("FAIL %s f%0d_r obs=%0d exp=%0d+-1", tag, j, o_r, er);
    end
    checks++;
    assert (o_i >= ei - 1 && o_i <= ei + 1) else begin
      errors++;
      $error("FAIL %s f%0d_i obs=%0d exp=%0d+-1", tag, j, o_i, ei);
    end
  endtask

  task automatic clear_cur();
    for (int j = 0; j < 8; j++) begin cur_r[j] = 0; cur_i[j] = 0; end
  endtask

  task automatic sb_reset();
    sb.delete();
    for (int k = 0; k < LAT - 1; k++) sb.push_back('0);
  endtask

  // One clock: drive cur now, push its expected result, compare the head due this edge.
  task automatic step();
    vec_t e;
    bit any;
    for (int j = 0; j < 8; j++) begin in_r[j] = W'(cur_r[j]); in_i[j] = W'(cur_i[j]); end
    model(e);
    @(posedge clk);
    sb.push_back(e);
    #1;
    if (sb.size() >= LAT) begin
      exp_v = sb.pop_front();
      cmp_vec("sb", exp_v);
    end
    any = 1'b0;
    for (int j = 0; j < 8; j++) if (out_r[j] != 0 || out_i[j] != 0) any = 1'b1;
    if (any) nz_cycles++;
  endtask

  initial begin
    zv = '0;
    rst_n = 1'b0;
    clear_cur();
    for (int j = 0; j < 8; j++) begin in_r[j] = 8'sd37; in_i[j] = -8'sd21; end
    #2;
    cmp_vec("rst_async", zv);
    repeat (3) @(negedge clk);
    cmp_vec("rst_hold", zv);
    rst_n = 1'b1;
    sb_reset();

    cur_r[6] = 16;
    repeat (21) step();
    for (int j = 0; j < 8; j++) near("qft_i110", j, t19_r[j], t19_i[j]);

    clear_cur();
    cur_r[0] = 16;
    repeat (LAT) step();
    for (int j = 0; j < 8; j++) near("qft_i000", j, 5, 0);

    clear_cur();
    repeat (LAT) step();
    nz_cycles = 0;
    cur_r[3] = 40;
    cur_i[3] = -24;
    step();
    clear_cur();
    repeat (LAT + 3) step();
    checks++;
    assert (nz_cycles == 1) else begin
      errors++;
      $error("FAIL impulse_cycles obs=%0d exp=1", nz_cycles);
    end

    for (int j = 0; j < 8; j++) begin
      cur_r[j] = (j % 2 == 1) ? LO : HI;
      cur_i[j] = (j < 4) ? HI : LO;
    end
    step();
    for (int k = 0; k < 24; k++) begin
      for (int j = 0; j < 8; j++) begin
        cur_r[j] = int'($urandom_range(0, (1 << W) - 1)) + LO;
        cur_i[j] = int'($urandom_range(0, (1 << W) - 1)) + LO;
      end
      step();
    end

    #3;
    rst_n = 1'b0;
    #1;
    cmp_vec("rst_mid", zv);
    @(posedge clk);
    #1;
    cmp_vec("rst_mid_edge", zv);
    @(negedge clk);
    rst_n = 1'b1;
    sb_reset();
    clear_cur();
    repeat (LAT + 1) step();

    cur_r[0] = HI;
    cur_r[4] = HI;
    repeat (LAT) step();
`ifdef QFT_SATURATE_EN
    sat_exp = 60;
`else
    sat_exp = -38;
`endif
    checks++;
    assert (int'(out_r[0]) == sat_exp) else begin
      errors++;
      $error("FAIL narrow_f000 obs=%0d exp=%0d", out_r[0], sat_exp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
